vppm_symbol_demod: RTL and testbench
====================================

# vppm_symbol_demod

VPPM symbol demodulator for the optical receiver chain. Sits directly downstream of the preamble frequency detector: takes the measured symbol period (in `clk` cycles) plus the raw photodetector bit stream, aligns to the preamble, decodes each symbol by comparing high-sample energy in its two halves, and emits parallel data words with a one-cycle valid strobe. Decoding by energy comparison keeps it dimming (duty-cycle) independent.

## Interface
- `PERIOD_W`, 32: width of the period input and the internal phase/energy counters.
- `DATA_W`, 8: bits per output word, MSB received first.
- `SYNC_SYMBOLS`, 4: minimum number of consecutive `0` preamble symbols before a delimiter is accepted.
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `signalIn` in 1: raw asynchronous VPPM line. Passes through a 2-FF synchronizer.
- `period_in` in PERIOD_W: symbol period in `clk` cycles.
- `period_valid` in 1: level. High when `period_in` is meaningful.
- `data_out` out DATA_W: last decoded word. Holds until the next word.
- `data_valid` out 1: one-cycle strobe when `data_out` is updated.
- `parity_err` out 1: qualifies `data_valid`. Constant 0 unless parity is compiled in.
- `frame_err` out 1: one-cycle strobe when a frame is truncated mid-word.
- `busy` out 1: high in PREAMBLE or DATA.

## Operation
- Symbol encoding: bit 0 = pulse in the first part of the period; bit 1 = pulse in the last part of the period.
- Per symbol:
  - `phase` counts 0..P-1; `half = P >> 1`.
  - `h1` counts synchronized-high samples with `phase < half`.
  - `h2` counts synchronized-high samples with `phase >= half`. For odd P, the second half holds the extra sample.
  - Decision at `phase == P-1`:
    - `h1 + h2 == 0` → idle symbol.
    - else if `h2 > h1` → 1.
    - else → 0 (ties decode as 0).
  - `h1`, `h2` and `phase` restart at 0 on the next cycle.
- States:
  - IDLE: when `period_valid` is high and `period_in >= 4`, latch P and go to HUNT. Periods below 4 are ignored.
  - HUNT:
    - If `period_valid` is low → IDLE.
    - Otherwise re-latch P each cycle.
    - On a synchronized rising edge: that cycle is phase 0 of the first symbol and its sample is counted; clear `pre_cnt` and go to PREAMBLE.
  - PREAMBLE, at each symbol decision:
    - 0 → `pre_cnt` += 1, saturating at `SYNC_SYMBOLS`.
    - 1 with `pre_cnt >= SYNC_SYMBOLS` → DATA with `bit_cnt = 0`. The delimiter symbol is not data.
    - 1 with `pre_cnt < SYNC_SYMBOLS` → HUNT.
    - idle → HUNT.
  - DATA, at each symbol decision:
    - 0 or 1 → shift into the word and increment `bit_cnt`.
    - After `DATA_W` bits (or `DATA_W + 1` with parity), load `data_out`, pulse `data_valid`, clear `bit_cnt` and stay in DATA for back-to-back words.
    - idle → HUNT. If `bit_cnt != 0`, also pulse `frame_err` and drop the partial word.
- P is frozen from leaving HUNT until returning to HUNT. `period_valid` changes mid-frame have no effect.

## Timing
- Reset values: `data_out = 0`, `data_valid = 0`, `parity_err = 0`, `frame_err = 0`, `busy = 0`. State = IDLE; synchronizer, counters and shift register cleared.
- Reset asserted mid-frame aborts immediately. No strobe is emitted.
- Synchronizer latency: 2 cycles from `signalIn` to the sampled value. Rising edge = sampled value high while the previous sample was low.
- Decision is made in the `phase == P-1` cycle. `data_valid` and `frame_err` are registered and assert on the following cycle for exactly 1 cycle.
- Back-to-back words: `data_valid` pulses exactly `DATA_W*P` cycles apart (`(DATA_W+1)*P` with parity).
- No realignment after HUNT: phase runs free from the capturing edge.

## Configuration
- `VPPM_PARITY_EN` defined:
  - One even-parity symbol follows each `DATA_W`-bit word.
  - `data_valid` fires after the parity symbol.
  - `parity_err = 1` on the same cycle when XOR of data bits and the parity bit is 1; otherwise 0.
- `VPPM_PARITY_EN` undefined: no parity symbol; `parity_err` is tied 0.

## Test plan
Common setup: P=10, `DATA_W=8`, `SYNC_SYMBOLS=4`, 30 % pulse duty.
- Reset held 5 cycles with line toggling → all outputs 0, `busy = 0`, no strobes.
- Preamble of 4 zeros, then 1, then 0xA5 → one `data_valid` with `data_out = 0xA5`, 1 cycle after the 8th data symbol's `phase 9`.
- Only 3 preamble zeros, then 1 → back to HUNT, `busy` drops, no `data_valid`.
- Valid preamble, 3 data bits, then an idle symbol → `frame_err` one-cycle pulse, then HUNT, no `data_valid`.
- Words 0x3C and 0xFF back-to-back → two `data_valid` pulses 80 cycles apart with correct data. Reset asserted mid-second-word → no second strobe.
- With `VPPM_PARITY_EN`: 0x01 with parity 0 → `parity_err = 1`; with parity 1 → `parity_err = 0`; pulses 90 cycles apart.

Source files
------------

// File: rtl/vppm_symbol_demod.sv
// vppm_symbol_demod
// VPPM symbol demodulator. Synchronizes the raw photodetector line, aligns to
// the first preamble rising edge, decides each symbol by comparing the number
// of high samples in the two halves of the period, and assembles DATA_W-bit
// words (MSB first) with a one-cycle data_valid strobe. Comparing energy in the
// two halves rather than looking for a fixed pulse width keeps the decision
// independent of the transmitter's dimming level.
//
// Optional feature macro: VPPM_PARITY_EN
//   When defined, every word is followed by one even-parity symbol and
//   parity_err qualifies data_valid. When undefined, parity_err is tied to 0.

module vppm_symbol_demod #(
  parameter int PERIOD_W     = 32,
  parameter int DATA_W       = 8,
  parameter int SYNC_SYMBOLS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signalIn,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                busy
);

  // Symbols per word, including the trailing parity symbol when enabled.
`ifdef VPPM_PARITY_EN
  localparam int WORD_SYMS = DATA_W + 1;
`else
  localparam int WORD_SYMS = DATA_W;
`endif

  localparam int BIT_CNT_W = $clog2(WORD_SYMS + 1);
  localparam int PRE_CNT_W = $clog2(SYNC_SYMBOLS + 1);

  localparam logic [BIT_CNT_W-1:0] WORD_LAST  = BIT_CNT_W'(WORD_SYMS - 1);
  localparam logic [PRE_CNT_W-1:0] SYNC_MAX   = PRE_CNT_W'(SYNC_SYMBOLS);
  localparam logic [PERIOD_W-1:0]  MIN_PERIOD = PERIOD_W'(4);

  // Receiver states.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HUNT     = 2'd1;
  localparam logic [1:0] PREAMBLE = 2'd2;
  localparam logic [1:0] DATA     = 2'd3;

  logic                 syncMeta;
  logic                 syncSample;
  logic                 prevSample;
  logic                 risingEdge;

  logic [1:0]           state;
  logic [PERIOD_W-1:0]  period;
  logic [PERIOD_W-1:0]  phase;
  logic [PERIOD_W-1:0]  h1;
  logic [PERIOD_W-1:0]  h2;
  logic [PERIOD_W-1:0]  h1Next;
  logic [PERIOD_W-1:0]  h2Next;
  logic [PERIOD_W-1:0]  half;
  logic                 inFirstHalf;
  logic                 symbolEnd;
  logic                 symIdle;
  logic                 symOne;
  logic                 inFrame;
  logic                 huntEdge;

  logic [PRE_CNT_W-1:0] preCnt;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic [WORD_SYMS-2:0] shiftReg;
  logic [WORD_SYMS-1:0] wordNext;
  logic                 wordDone;

  // Two-flop synchronizer for the asynchronous line, plus one more stage of
  // history so a rising edge can be recognised on the sampled value.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta   <= 1'b0;
      syncSample <= 1'b0;
      prevSample <= 1'b0;
    end else begin
      syncMeta   <= signalIn;
      syncSample <= syncMeta;
      prevSample <= syncSample;
    end
  end

  assign risingEdge = syncSample & ~prevSample;

  // The capturing edge in HUNT is phase 0 of the first preamble symbol; a low
  // period_valid takes priority and sends the receiver back to IDLE instead.
  assign huntEdge = (state == HUNT) && period_valid && risingEdge;
  assign inFrame  = (state == PREAMBLE) || (state == DATA);
  assign busy     = inFrame;

  // Half-period split; for odd periods the second half gets the extra sample.
  assign half        = period >> 1;
  assign inFirstHalf = (phase < half);
  assign symbolEnd   = (phase == (period - PERIOD_W'(1)));

  // Energy of the symbol so far including the current cycle's sample, so the
  // decision made in the last phase already accounts for that last sample.
  always_comb begin
    h1Next = h1;
    h2Next = h2;
    if (syncSample) begin
      if (inFirstHalf) begin
        h1Next = h1 + PERIOD_W'(1);
      end else begin
        h2Next = h2 + PERIOD_W'(1);
      end
    end
  end

  // No energy at all means the line went quiet; otherwise the heavier half
  // wins and ties fall to 0.
  assign symIdle = (h1Next == '0) && (h2Next == '0);
  assign symOne  = (h2Next > h1Next);

  // Word assembly: previously received symbols with the new one appended.
  assign wordNext = {shiftReg, symOne};
  assign wordDone = (bitCnt == WORD_LAST);

  // Phase and per-half energy counters; they run freely from the capturing
  // edge with no realignment and restart right after every decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      h1    <= '0;
      h2    <= '0;
    end else if (huntEdge) begin
      phase <= PERIOD_W'(1);
      h1    <= PERIOD_W'(1);
      h2    <= '0;
    end else if (inFrame) begin
      if (symbolEnd) begin
        phase <= '0;
        h1    <= '0;
        h2    <= '0;
      end else begin
        phase <= phase + PERIOD_W'(1);
        h1    <= h1Next;
        h2    <= h2Next;
      end
    end else begin
      phase <= '0;
      h1    <= '0;
      h2    <= '0;
    end
  end

  // Receiver state machine: period capture, preamble qualification and
  // symbol-to-word assembly. The period is frozen while in a frame so
  // period_valid or period_in changes mid-frame have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      period   <= '0;
      preCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (period_valid && (period_in >= MIN_PERIOD)) begin
            period <= period_in;
            state  <= HUNT;
          end
        end

        HUNT: begin
          if (!period_valid) begin
            state <= IDLE;
          end else begin
            // Too-short periods are never accepted, so keep the last good one.
            if (period_in >= MIN_PERIOD) begin
              period <= period_in;
            end
            if (risingEdge) begin
              preCnt <= '0;
              state  <= PREAMBLE;
            end
          end
        end

        PREAMBLE: begin
          if (symbolEnd) begin
            if (symIdle) begin
              state <= HUNT;
            end else if (!symOne) begin
              if (preCnt < SYNC_MAX) begin
                preCnt <= preCnt + PRE_CNT_W'(1);
              end
            end else if (preCnt >= SYNC_MAX) begin
              // Delimiter accepted; it carries no data itself.
              state    <= DATA;
              bitCnt   <= '0;
              shiftReg <= '0;
            end else begin
              state <= HUNT;
            end
          end
        end

        DATA: begin
          if (symbolEnd) begin
            if (symIdle) begin
              state    <= HUNT;
              bitCnt   <= '0;
              shiftReg <= '0;
            end else if (wordDone) begin
              bitCnt   <= '0;
              shiftReg <= '0;
            end else begin
              bitCnt   <= bitCnt + BIT_CNT_W'(1);
              shiftReg <= wordNext[WORD_SYMS-2:0];
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output word register and the one-cycle strobes, all registered so they
  // appear the cycle after the deciding phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if ((state == DATA) && symbolEnd) begin
        if (symIdle) begin
          frame_err <= (bitCnt != '0);
        end else if (wordDone) begin
          data_out   <= wordNext[WORD_SYMS-1 -: DATA_W];
          data_valid <= 1'b1;
        end
      end
    end
  end

`ifdef VPPM_PARITY_EN
  // Even parity over data bits plus parity symbol, aligned with data_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if ((state == DATA) && symbolEnd && !symIdle && wordDone) begin
        parity_err <= ^wordNext;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_vppm_symbol_demod.sv
// tb_vppm_symbol_demod
// Self-checking bench for vppm_symbol_demod. Frames are described as symbol
// lists (0, 1, 2 = idle) and a symbol-level protocol model turns each list into
// per-cycle expected outputs; a negedge process compares the DUT every cycle.
// Honours VPPM_PARITY_EN the same way the design does.
`timescale 1ns/1ps

module tb_vppm_symbol_demod;

  localparam int PERIOD_W = 32;
  localparam int DATA_W   = 8;
  localparam int SYNC     = 4;
`ifdef VPPM_PARITY_EN
  localparam int WORD_SYMS = DATA_W + 1;
  localparam bit PARITY_ON = 1'b1;
`else
  localparam int WORD_SYMS = DATA_W;
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int MAXC = 30000;

  logic                clk = 1'b0;
  logic                rst;
  logic                signalIn;
  logic [PERIOD_W-1:0] period_in;
  logic                period_valid;
  logic [DATA_W-1:0]   data_out;
  logic                data_valid;
  logic                parity_err;
  logic                frame_err;
  logic                busy;

  vppm_symbol_demod #(
    .PERIOD_W    (PERIOD_W),
    .DATA_W      (DATA_W),
    .SYNC_SYMBOLS(SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signalIn    (signalIn),
    .period_in   (period_in),
    .period_valid(period_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Per-cycle expectations produced by the model.
  bit              expBusy  [MAXC];
  bit              expValid [MAXC];
  bit              expFerr  [MAXC];
  bit              expPerr  [MAXC];
  bit [DATA_W-1:0] expData  [MAXC];

  int checks = 0;
  int passes = 0;

  int              txSyms[$];
  int              modelStrobe[$];
  int              stopIdx;
  int              frameE;

  bit              checkEn = 1'b0;
  bit              prevBusy = 1'b0;
  int              validCount = 0;
  int              ferrCount = 0;
  int              lastFerrCycle = -1;
  int              lastBusyFall = -1;
  int              obsValidCycle[$];
  logic [DATA_W-1:0] obsValidData[$];
  logic            obsPerr[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic schedStrobe(input int c, input logic [DATA_W-1:0] d, input bit pe);
    if (c < MAXC) begin
      expValid[c] = 1'b1;
      expPerr[c]  = pe;
      for (int i = c; i < MAXC; i++) expData[i] = d;
    end
  endtask

  task automatic expectResetFrom(input int r);
    for (int i = r + 1; i < MAXC; i++) begin
      expBusy[i]  = 1'b0;
      expValid[i] = 1'b0;
      expFerr[i]  = 1'b0;
      expPerr[i]  = 1'b0;
      expData[i]  = '0;
    end
  endtask

  // Symbol-level protocol model: symbol k of a frame whose capturing edge is
  // sampled in cycle e ends at e+(k+1)*p-1, so its results appear at e+(k+1)*p.
  task automatic modelFrame(input int e, input int p);
    int                   preCnt;
    bit                   inData;
    int                   nBits;
    logic [WORD_SYMS-1:0] word;
    int                   s;
    preCnt  = 0;
    inData  = 1'b0;
    nBits   = 0;
    word    = '0;
    stopIdx = txSyms.size() - 1;
    modelStrobe.delete();
    for (int k = 0; k < txSyms.size(); k++) begin
      s = e + (k + 1) * p;
      if (!inData) begin
        if (txSyms[k] == 0) begin
          if (preCnt < SYNC) preCnt++;
        end else if (txSyms[k] == 1 && preCnt >= SYNC) begin
          inData = 1'b1;
          nBits  = 0;
        end else begin
          stopIdx = k;
          break;
        end
      end else if (txSyms[k] == 2) begin
        if (nBits != 0 && s < MAXC) expFerr[s] = 1'b1;
        stopIdx = k;
        break;
      end else begin
        word = {word[WORD_SYMS-2:0], 1'(txSyms[k] == 1)};
        nBits++;
        if (nBits == WORD_SYMS) begin
          nBits = 0;
          modelStrobe.push_back(s);
          schedStrobe(s, word[WORD_SYMS-1 -: DATA_W], PARITY_ON ? ^word : 1'b0);
        end
      end
    end
    for (int c = e + 1; c < e + (stopIdx + 1) * p && c < MAXC; c++) expBusy[c] = 1'b1;
  endtask

  task automatic pushPreamble(input int nZeros);
    for (int i = 0; i < nZeros; i++) txSyms.push_back(0);
    txSyms.push_back(1);
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] d, input bit pbit);
    for (int i = DATA_W - 1; i >= 0; i--) txSyms.push_back(d[i] ? 1 : 0);
    if (PARITY_ON) txSyms.push_back(pbit ? 1 : 0);
  endtask

  // Drives txSyms on the line with a random pulse width per symbol. Optionally
  // disturbs period_in/period_valid mid-frame, or aborts with a reset at phase
  // 5 of symbol abortSym.
  task automatic applyStimulus(input int p, input bit scramble, input int abortSym);
    int w;
    bit aborted;
    aborted = 1'b0;
    w = 1;
    stepCycle();
    frameE = cycle + 2;
    modelFrame(frameE, p);
    for (int k = 0; k <= stopIdx; k++) begin
      if (aborted) break;
      if (scramble && k > 0 && k == stopIdx / 2) begin
        period_in    = PERIOD_W'($urandom_range(4, 20));
        period_valid = 1'($urandom_range(0, 1));
      end
      for (int ph = 0; ph < p; ph++) begin
        if (!(k == 0 && ph == 0)) stepCycle();
        if (ph == 0) w = $urandom_range(1, p >> 1);
        if (k == abortSym && ph == 5) begin
          signalIn = 1'b0;
          rst      = 1'b1;
          expectResetFrom(cycle);
          gap(3);
          rst     = 1'b0;
          aborted = 1'b1;
          break;
        end
        case (txSyms[k])
          0:       signalIn = (ph < w);
          1:       signalIn = (ph >= p - w);
          default: signalIn = 1'b0;
        endcase
      end
    end
    stepCycle();
    signalIn = 1'b0;
  endtask

  // Per-cycle comparison against the model, plus event capture for the
  // hand-computed checks.
  always @(negedge clk) begin
    if (checkEn && cycle < MAXC) begin
      checkOutput($sformatf("outputs@%0d", cycle),
                  64'({busy, data_valid, frame_err, parity_err, data_out}),
                  64'({expBusy[cycle], expValid[cycle], expFerr[cycle],
                       expPerr[cycle], expData[cycle]}));
      if (data_valid === 1'b1) begin
        validCount++;
        obsValidCycle.push_back(cycle);
        obsValidData.push_back(data_out);
        obsPerr.push_back(parity_err);
      end
      if (frame_err === 1'b1) begin
        ferrCount++;
        lastFerrCycle = cycle;
      end
      if (prevBusy && busy === 1'b0) lastBusyFall = cycle;
      prevBusy = (busy === 1'b1);
    end
  end

  function automatic int lastCycle(input int back);
    int n;
    n = obsValidCycle.size();
    return (n > back) ? obsValidCycle[n - 1 - back] : -1;
  endfunction

  function automatic logic [DATA_W-1:0] lastData(input int back);
    int n;
    n = obsValidData.size();
    return (n > back) ? obsValidData[n - 1 - back] : 'x;
  endfunction

  function automatic logic lastPerrVal(input int back);
    int n;
    n = obsPerr.size();
    return (n > back) ? obsPerr[n - 1 - back] : 1'bx;
  endfunction

  initial begin
    #(MAXC * 10);
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0;
    int f0;
    int p;
    logic [DATA_W-1:0] d;
    bit pb;

    rst          = 1'b1;
    signalIn     = 1'b0;
    period_valid = 1'b0;
    period_in    = '0;
    stepCycle();
    checkEn = 1'b1;

    // Reset held with the line toggling: nothing may come out.
    period_valid = 1'b1;
    period_in    = PERIOD_W'(10);
    for (int i = 0; i < 5; i++) begin
      signalIn = 1'($urandom_range(0, 1));
      stepCycle();
    end
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_data_out", 64'(data_out), 64'd0);
    checkOutput("reset_strobes", 64'(validCount + ferrCount), 64'd0);
    rst      = 1'b0;
    signalIn = 1'b0;
    gap(6);

    // 4 preamble zeros, delimiter, 0xA5, idle.
    txSyms.delete();
    pushPreamble(4);
    pushWord(8'hA5, 1'b0);
    txSyms.push_back(2);
    v0 = validCount;
    applyStimulus(10, 1'b0, -1);
    gap(8);
    checkOutput("model_a5_strobe", 64'(modelStrobe.size() > 0 ? modelStrobe[0] : -1),
                64'(frameE + (5 + WORD_SYMS) * 10));
    checkOutput("a5_count", 64'(validCount - v0), 64'd1);
    checkOutput("a5_data", 64'(lastData(0)), 64'h0A5);
    checkOutput("a5_cycle", 64'(lastCycle(0)), 64'(frameE + (5 + WORD_SYMS) * 10));
    checkOutput("a5_parity_err", 64'(lastPerrVal(0)), 64'd0);

    // Only 3 preamble zeros before the 1: back to HUNT.
    txSyms.delete();
    pushPreamble(3);
    v0 = validCount;
    applyStimulus(10, 1'b0, -1);
    gap(8);
    checkOutput("model_short_pre_stop", 64'(stopIdx), 64'd3);
    checkOutput("short_pre_busy_fall", 64'(lastBusyFall), 64'(frameE + 40));
    checkOutput("short_pre_no_valid", 64'(validCount - v0), 64'd0);

    // Valid preamble, 3 data bits, idle: frame error.
    txSyms.delete();
    pushPreamble(4);
    txSyms.push_back(1);
    txSyms.push_back(0);
    txSyms.push_back(1);
    txSyms.push_back(2);
    v0 = validCount;
    f0 = ferrCount;
    applyStimulus(10, 1'b0, -1);
    gap(8);
    checkOutput("ferr_count", 64'(ferrCount - f0), 64'd1);
    checkOutput("ferr_cycle", 64'(lastFerrCycle), 64'(frameE + 90));
    checkOutput("ferr_no_valid", 64'(validCount - v0), 64'd0);
    checkOutput("ferr_busy_fall", 64'(lastBusyFall), 64'(frameE + 90));

    // Back-to-back 0x3C, 0xFF.
    txSyms.delete();
    pushPreamble(4);
    pushWord(8'h3C, 1'b0);
    pushWord(8'hFF, 1'b0);
    txSyms.push_back(2);
    v0 = validCount;
    applyStimulus(10, 1'b0, -1);
    gap(8);
    checkOutput("b2b_count", 64'(validCount - v0), 64'd2);
    checkOutput("b2b_first", 64'(lastData(1)), 64'h03C);
    checkOutput("b2b_second", 64'(lastData(0)), 64'h0FF);
    checkOutput("b2b_spacing", 64'(lastCycle(0) - lastCycle(1)), 64'(WORD_SYMS * 10));

    // Same frame, reset in the middle of the second word.
    txSyms.delete();
    pushPreamble(4);
    pushWord(8'h3C, 1'b0);
    pushWord(8'hFF, 1'b0);
    txSyms.push_back(2);
    v0 = validCount;
    applyStimulus(10, 1'b0, 5 + WORD_SYMS + 3);
    gap(8);
    checkOutput("abort_count", 64'(validCount - v0), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_data_out", 64'(data_out), 64'd0);

    if (PARITY_ON) begin
      // 0x01 with wrong parity, then 0x01 with correct parity.
      txSyms.delete();
      pushPreamble(4);
      pushWord(8'h01, 1'b0);
      pushWord(8'h01, 1'b1);
      txSyms.push_back(2);
      v0 = validCount;
      applyStimulus(10, 1'b0, -1);
      gap(8);
      checkOutput("par_count", 64'(validCount - v0), 64'd2);
      checkOutput("par_bad", 64'(lastPerrVal(1)), 64'd1);
      checkOutput("par_good", 64'(lastPerrVal(0)), 64'd0);
      checkOutput("par_spacing", 64'(lastCycle(0) - lastCycle(1)), 64'd90);
    end

    // Randomized frames with random periods, duty and mid-frame period noise.
    for (int f = 0; f < 25; f++) begin
      p            = $urandom_range(4, 16);
      period_in    = PERIOD_W'(p);
      period_valid = 1'b1;
      gap(3 + $urandom_range(0, 5));
      txSyms.delete();
      pushPreamble($urandom_range(1, 6));
      for (int wi = 0; wi < $urandom_range(0, 2); wi++) begin
        d  = DATA_W'($urandom);
        pb = (^d) ^ ($urandom_range(0, 3) == 0);
        pushWord(d, pb);
      end
      for (int b = 0; b < $urandom_range(0, WORD_SYMS - 1); b++)
        txSyms.push_back($urandom_range(0, 1));
      txSyms.push_back(2);
      applyStimulus(p, 1'b1, -1);
    end
    period_valid = 1'b1;
    gap(20);
    checkEn = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
